// File: rtl/bus_lv1_lv2_arbiter_proc.sv
// Per-core arbiter for the shared lv1-lv2 bus.
// Resolves bus requests from the L1 instruction cache (IL) and L1 data cache
// (DL): round-robin on ties, grant held while the owner keeps requesting, a
// one-cycle all-idle turnaround between owners, a hold-time watchdog that
// revokes an ownership after MAX_HOLD cycles, and wrapping grant counters.
//
// Ports:
//   clk                      clock, all logic on rising edge
//   rst_n                    synchronous active-low reset
//   bus_lv1_lv2_req_proc_il  request from L1 instruction cache
//   bus_lv1_lv2_req_proc_dl  request from L1 data cache
//   bus_lv1_lv2_gnt_proc_il  registered grant to instruction cache
//   bus_lv1_lv2_gnt_proc_dl  registered grant to data cache
//   bus_lv1_lv2_gnt_proc     registered OR of both grants
//   gnt_cnt_il / gnt_cnt_dl  wrapping count of ownerships granted
//   timeout_err              sticky watchdog revocation flag
module bus_lv1_lv2_arbiter_proc #(
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned HOLD_WID = 7,
  parameter int unsigned CNT_WID  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bus_lv1_lv2_req_proc_il,
  input  logic               bus_lv1_lv2_req_proc_dl,
  output logic               bus_lv1_lv2_gnt_proc_il,
  output logic               bus_lv1_lv2_gnt_proc_dl,
  output logic               bus_lv1_lv2_gnt_proc,
  output logic [CNT_WID-1:0] gnt_cnt_il,
  output logic [CNT_WID-1:0] gnt_cnt_dl,
  output logic               timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IL = 2'd1;
  localparam logic [1:0] GNT_DL = 2'd2;
  localparam logic [1:0] TURN   = 2'd3;

  localparam logic OWN_IL = 1'b0;
  localparam logic OWN_DL = 1'b1;

  logic [1:0]          state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic [HOLD_WID-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_WID-1:0]  cnt_il_q, cnt_il_d;
  logic [CNT_WID-1:0]  cnt_dl_q, cnt_dl_d;
  logic                gnt_il_q, gnt_il_d;
  logic                gnt_dl_q, gnt_dl_d;
  logic                gnt_q, gnt_d;
  logic                timeout_q, timeout_d;

  logic                win_il, win_dl;
  logic                hold_expired;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    cnt_il_d     = cnt_il_q;
    cnt_dl_d     = cnt_dl_q;
    timeout_d    = timeout_q;
    gnt_il_d     = 1'b0;
    gnt_dl_d     = 1'b0;

    // On a tie the requester that did not own the bus last wins.
    win_il = bus_lv1_lv2_req_proc_il &&
             (!bus_lv1_lv2_req_proc_dl || (last_owner_q == OWN_DL));
    win_dl = bus_lv1_lv2_req_proc_dl &&
             (!bus_lv1_lv2_req_proc_il || (last_owner_q == OWN_IL));

    // Last permitted cycle of the current ownership; disabled when MAX_HOLD is 0.
    hold_expired = (MAX_HOLD != 0) &&
                   (hold_cnt_q == HOLD_WID'(MAX_HOLD - 1));

    case (state_q)
      IDLE, TURN: begin
        if (win_il) begin
          state_d      = GNT_IL;
          gnt_il_d     = 1'b1;
          last_owner_d = OWN_IL;
          hold_cnt_d   = '0;
          cnt_il_d     = cnt_il_q + CNT_WID'(1);
        end else if (win_dl) begin
          state_d      = GNT_DL;
          gnt_dl_d     = 1'b1;
          last_owner_d = OWN_DL;
          hold_cnt_d   = '0;
          cnt_dl_d     = cnt_dl_q + CNT_WID'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GNT_IL: begin
        if (!bus_lv1_lv2_req_proc_il) begin
          state_d = TURN;
        end else if (hold_expired) begin
          state_d   = TURN;
          timeout_d = 1'b1;
        end else begin
          gnt_il_d   = 1'b1;
          hold_cnt_d = hold_cnt_q + HOLD_WID'(1);
        end
      end
      GNT_DL: begin
        if (!bus_lv1_lv2_req_proc_dl) begin
          state_d = TURN;
        end else if (hold_expired) begin
          state_d   = TURN;
          timeout_d = 1'b1;
        end else begin
          gnt_dl_d   = 1'b1;
          hold_cnt_d = hold_cnt_q + HOLD_WID'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = gnt_il_d | gnt_dl_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_DL;
      hold_cnt_q   <= '0;
      cnt_il_q     <= '0;
      cnt_dl_q     <= '0;
      gnt_il_q     <= 1'b0;
      gnt_dl_q     <= 1'b0;
      gnt_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      cnt_il_q     <= cnt_il_d;
      cnt_dl_q     <= cnt_dl_d;
      gnt_il_q     <= gnt_il_d;
      gnt_dl_q     <= gnt_dl_d;
      gnt_q        <= gnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus_lv1_lv2_gnt_proc_il = gnt_il_q;
  assign bus_lv1_lv2_gnt_proc_dl = gnt_dl_q;
  assign bus_lv1_lv2_gnt_proc    = gnt_q;
  assign gnt_cnt_il              = cnt_il_q;
  assign gnt_cnt_dl              = cnt_dl_q;
  assign timeout_err             = timeout_q;

endmodule

// File: tb/tb_bus_lv1_lv2_arbiter_proc.sv
// Bench for bus_lv1_lv2_arbiter_proc with MAX_HOLD=8, CNT_WID=2 so that the
// watchdog and counter wrap are reachable in a few cycles.
module tb_bus_lv1_lv2_arbiter_proc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_il = 1'b0;
  logic       req_dl = 1'b0;
  logic       gnt_il, gnt_dl, gnt;
  logic [1:0] cnt_il, cnt_dl;
  logic       tmo;

  int unsigned check_cnt = 0;
  int unsigned err_cnt   = 0;

  logic [7:0] sb_q[$];

  // Reference model state
  int   m_st;      // 0 idle, 1 IL owns, 2 DL owns, 3 turnaround
  int   m_last;    // 0 IL, 1 DL
  int   m_hold;
  int   m_cil, m_cdl;
  logic m_gil, m_gdl, m_to;

  bus_lv1_lv2_arbiter_proc #(
    .MAX_HOLD(8),
    .HOLD_WID(4),
    .CNT_WID (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus_lv1_lv2_req_proc_il(req_il),
    .bus_lv1_lv2_req_proc_dl(req_dl),
    .bus_lv1_lv2_gnt_proc_il(gnt_il),
    .bus_lv1_lv2_gnt_proc_dl(gnt_dl),
    .bus_lv1_lv2_gnt_proc   (gnt),
    .gnt_cnt_il             (cnt_il),
    .gnt_cnt_dl             (cnt_dl),
    .timeout_err            (tmo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_step(input logic rst, input logic il, input logic dl);
    logic pick_il, pick_dl;
    if (!rst) begin
      m_st = 0; m_last = 1; m_hold = 0; m_cil = 0; m_cdl = 0;
      m_gil = 1'b0; m_gdl = 1'b0; m_to = 1'b0;
    end else if (m_st == 0 || m_st == 3) begin
      pick_il = (il && dl) ? (m_last == 1) : il;
      pick_dl = dl && !pick_il;
      m_gil = pick_il;
      m_gdl = pick_dl;
      m_hold = 0;
      if (pick_il) begin
        m_st = 1; m_last = 0; m_cil = (m_cil + 1) % 4;
      end else if (pick_dl) begin
        m_st = 2; m_last = 1; m_cdl = (m_cdl + 1) % 4;
      end else begin
        m_st = 0;
      end
    end else begin
      // Owner is IL in state 1, DL in state 2; the other request is ignored.
      if (!((m_st == 1) ? il : dl)) begin
        m_st = 3; m_gil = 1'b0; m_gdl = 1'b0;
      end else if (m_hold == 7) begin
        m_st = 3; m_gil = 1'b0; m_gdl = 1'b0; m_to = 1'b1;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [7:0] m_pack();
    logic [1:0] ci, cd;
    ci = 2'(m_cil);
    cd = 2'(m_cdl);
    return {m_to, m_gil | m_gdl, m_gdl, m_gil, cd, ci};
  endfunction

  // Drive one cycle of stimulus, queue the expected outputs, then compare
  // them against the DUT one time unit after the edge.
  task automatic cycle(input logic rst, input logic il, input logic dl);
    logic [7:0] exp;
    rst_n  = rst;
    req_il = il;
    req_dl = dl;
    m_step(rst, il, dl);
    sb_q.push_back(m_pack());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check_eq("outputs", {24'd0, tmo, gnt, gnt_dl, gnt_il, cnt_dl, cnt_il}, {24'd0, exp});
      check_eq("no_overlap", {31'd0, gnt_il & gnt_dl}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned hi_cnt;

    // Reset with both requests high, then IL wins the first tie.
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("rst_state", {24'd0, tmo, gnt, gnt_dl, gnt_il, cnt_dl, cnt_il}, 32'd0);
    cycle(1'b1, 1'b1, 1'b1);
    check_eq("first_tie_il", {30'd0, gnt_dl, gnt_il}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);

    // Single requester.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    check_eq("single_gnt_held", {31'd0, gnt_il}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("single_gnt_drop", {31'd0, gnt_il}, 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("single_cnt_il", {30'd0, cnt_il}, 32'd1);
    check_eq("single_cnt_dl", {30'd0, cnt_dl}, 32'd0);

    // Contention and round-robin hand-over.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("rr_gap", {31'd0, gnt}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("rr_dl_owner", {30'd0, gnt_dl, gnt_il}, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    check_eq("rr_dl_kept", {30'd0, gnt_dl, gnt_il}, 32'd2);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("rr_il_back", {30'd0, gnt_dl, gnt_il}, 32'd1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("rr_cnt_il", {30'd0, cnt_il}, 32'd2);
    check_eq("rr_cnt_dl", {30'd0, cnt_dl}, 32'd1);

    // Watchdog, IL alone: 8 grant cycles, revoke, gap, re-grant.
    cycle(1'b0, 1'b0, 1'b0);
    hi_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (gnt_il) hi_cnt++;
    end
    check_eq("wd_hold_len", hi_cnt, 32'd8);
    check_eq("wd_timeout", {31'd0, tmo}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("wd_regrant_cnt", {30'd0, cnt_il}, 32'd2);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("wd_sticky", {31'd0, tmo}, 32'd1);

    // Watchdog with DL waiting: DL takes over after the gap.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1);
    check_eq("wd_dl_takes", {30'd0, gnt_dl, gnt_il}, 32'd2);
    check_eq("wd_dl_tmo", {31'd0, tmo}, 32'd1);

    // Reset in the middle of a DL ownership.
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("midrst_clear", {24'd0, tmo, gnt, gnt_dl, gnt_il, cnt_dl, cnt_il}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0);

    // Counter wrap: five separate IL ownerships in a 2-bit counter.
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    check_eq("wrap_cnt_il", {30'd0, cnt_il}, 32'd1);

    // A short random tail, checked by the model.
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
